// File: rtl/fifo_adapter_pkg.sv
// Shared constants and helpers for the FIFO read-side FWFT adapter.
// Stateless: no latency, no handshake.
package fifo_adapter_pkg;

  localparam int C_MAX_RD_LATENCY = 3;

  // Width needed to hold a level in the range 0..depth.
  function automatic int f_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_fwft_adapter_if.sv
// FIFO-facing read port plus the downstream valid/ready stream of the FWFT adapter.
// The master is the adapter; the slave side is the FIFO model and stream sink together.
interface fifo_fwft_adapter_if
  import fifo_adapter_pkg::*;
#(
  parameter int G_WIDTH      = 8,
  parameter int G_RD_LATENCY = 1
);

  localparam int C_LVL_W = f_level_w(G_RD_LATENCY + 1);

  logic               i_fifo_empty;
  logic [G_WIDTH-1:0] i_fifo_data;
  logic               o_fifo_rd;
  logic               o_valid;
  logic               i_ready;
  logic [G_WIDTH-1:0] o_data;
  logic [C_LVL_W-1:0] o_level;
  logic               o_err;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_ready,
    output o_fifo_rd, o_valid, o_data, o_level, o_err
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_ready,
    input  o_fifo_rd, o_valid, o_data, o_level, o_err
  );

endinterface

// File: rtl/fifo_fwft_adapter_buf.sv
// Circular register buffer; push data visible at rdata one cycle later, no bypass.
// No internal backpressure: a push into a full buffer without a pop is dropped and flags err.
module fwft_buf
  import fifo_adapter_pkg::*;
#(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic [G_WIDTH-1:0]              wdata,
  output logic [G_WIDTH-1:0]              rdata,
  output logic [f_level_w(G_DEPTH)-1:0]   count,
  output logic                            err
);

  localparam int C_PTR_W = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
  localparam int C_LVL_W = f_level_w(G_DEPTH);

  logic [G_WIDTH-1:0] mem [G_DEPTH];
  logic [C_PTR_W-1:0] head;
  logic [C_PTR_W-1:0] tail;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] ptr);
    return (ptr == C_PTR_W'(G_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == C_LVL_W'(G_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the head slot, so a push at full is still accepted.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[head];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < G_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= f_next(tail);
      end
      if (do_pop) begin
        head <= f_next(head);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (push && !do_push) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_fwft_adapter.sv
// Turns a registered-read FIFO into a FWFT valid/ready stream; o_valid trails o_fifo_rd by G_RD_LATENCY+1.
// Reads are only issued when buffer plus in-flight words fit, so i_ready low stalls the FIFO losslessly.
module fifo_fwft_adapter
  import fifo_adapter_pkg::*;
#(
  parameter int G_WIDTH      = 8,
  parameter int G_RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fifo_fwft_adapter_if.master  bus
);

  localparam int C_DEPTH = G_RD_LATENCY + 1;
  localparam int C_LVL_W = f_level_w(C_DEPTH);
  localparam int C_SUM_W = C_LVL_W + 1;

  logic [G_RD_LATENCY-1:0] rd_pipe;
  logic [C_LVL_W-1:0]      count;
  logic [C_LVL_W-1:0]      inflight;
  logic [C_SUM_W-1:0]      occupancy;
  logic [G_WIDTH-1:0]      rdata;
  logic                    valid;
  logic                    pop;
  logic                    push;
  logic                    issue;
  logic                    err;

  assign valid = (count != '0);
  assign pop   = valid & bus.i_ready;
  assign push  = rd_pipe[G_RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int k = 0; k < G_RD_LATENCY; k++) begin
      inflight = inflight + C_LVL_W'(rd_pipe[k]);
    end
  end

  // Counting this cycle's pop lets a full buffer keep reading at one word per cycle.
  assign occupancy = C_SUM_W'(count) + C_SUM_W'(inflight) - C_SUM_W'(pop);
  assign issue     = ~bus.i_fifo_empty & (occupancy < C_SUM_W'(C_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= issue;
      for (int k = 1; k < G_RD_LATENCY; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
      end
    end
  end

  fwft_buf #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (C_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.i_fifo_data),
    .rdata   (rdata),
    .count   (count),
    .err     (err)
  );

  assign bus.o_fifo_rd = issue & i_rst_n;
  assign bus.o_valid   = valid;
  assign bus.o_data    = rdata;
  assign bus.o_level   = count;
  assign bus.o_err     = err;

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Bench for fifo_fwft_adapter: behavioural latency-1 FIFO in front, scoreboard queue behind.
module tb_fifo_fwft_adapter;

  localparam int W = 8;
  localparam int L = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_fwft_adapter_if #(.G_WIDTH(W), .G_RD_LATENCY(L)) bus ();

  fifo_fwft_adapter #(.G_WIDTH(W), .G_RD_LATENCY(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr;
  logic [7:0] fifo_dat;
  logic [7:0] exp_q [$];
  logic       underflow = 1'b0;
  logic       prev_vld  = 1'b0;
  logic       prev_rdy  = 1'b0;
  logic [7:0] prev_dat  = 8'h00;

  assign bus.i_fifo_empty = (wr_ptr == rd_ptr);
  assign bus.i_fifo_data  = fifo_dat;

  // Synchronous FIFO model with one cycle of registered read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 0;
      fifo_dat <= 8'h00;
    end else if (bus.o_fifo_rd && (wr_ptr != rd_ptr)) begin
      fifo_dat <= fifo_mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_push(input logic [7:0] v);
    fifo_mem[wr_ptr[7:0]] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard pops, stream-hold rule, underflow watch.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk("hold_vld", bus.o_valid, 1);
        chk("hold_dat", bus.o_data, prev_dat);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) chk("extra_word", bus.o_valid, 0);
        else                   chk("data", bus.o_data, exp_q.pop_front());
      end
      if (bus.o_fifo_rd && bus.i_fifo_empty) underflow = 1'b1;
      prev_vld = bus.o_valid;
      prev_rdy = bus.i_ready;
      prev_dat = bus.o_data;
    end
  end

  initial begin
    int rd_cnt, rd_first, rd_last, v_cnt, v_first, v_last;
    bus.i_ready = 1'b0;
    #1 rst_n = 1'b0;

    // 1: reset values, then a single word with latency 1
    tick();
    fifo_push(8'hA1);
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_level", bus.o_level, 0);
    chk("rst_err",   bus.o_err,   0);
    chk("rst_data",  bus.o_data,  0);
    chk("rst_rd",    bus.o_fifo_rd, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_rd_c0",  bus.o_fifo_rd, 1);
    chk("t1_vld_c0", bus.o_valid, 0);
    tick(); @(negedge clk);
    chk("t1_rd_c1",  bus.o_fifo_rd, 0);
    chk("t1_vld_c1", bus.o_valid, 0);
    tick(); @(negedge clk);
    chk("t1_vld_c2", bus.o_valid, 1);
    chk("t1_lvl_c2", bus.o_level, 1);
    tick(); @(negedge clk);
    chk("t1_lvl_c3", bus.o_level, 0);
    chk("t1_vld_c3", bus.o_valid, 0);

    // 2: sixteen-word stream at full rate
    tick();
    for (int v = 0; v < 16; v++) fifo_push(8'(v));
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    v_cnt = 0;  v_first = -1;  v_last = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_fifo_rd) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = i;
        rd_last = i;
      end
      if (bus.o_valid) begin
        v_cnt++;
        if (v_first < 0) v_first = i;
        v_last = i;
      end
    end
    chk("t2_rd_cnt",  rd_cnt, 16);
    chk("t2_rd_span", rd_last - rd_first + 1, 16);
    chk("t2_v_cnt",   v_cnt, 16);
    chk("t2_v_span",  v_last - v_first + 1, 16);
    chk("t2_err",     bus.o_err, 0);
    chk("t2_drain",   exp_q.size(), 0);

    // 3: sink stalled with five words waiting
    tick();
    bus.i_ready = 1'b0;
    for (int v = 0; v < 5; v++) fifo_push(8'h30 + 8'(v));
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_fifo_rd) rd_cnt++;
    end
    chk("t3_rd_cnt", rd_cnt, 2);
    chk("t3_level",  bus.o_level, 2);
    chk("t3_rd_off", bus.o_fifo_rd, 0);
    tick();
    bus.i_ready = 1'b1;
    wait_drain("t3_drain", 30);
    tick(); @(negedge clk);
    chk("t3_level_end", bus.o_level, 0);

    // 4: alternating ready with continuous supply
    tick();
    for (int v = 0; v < 20; v++) fifo_push(8'h60 + 8'(v));
    for (int i = 0; i < 40; i++) begin
      bus.i_ready = (i % 2 == 0);
      tick();
    end
    bus.i_ready = 1'b1;
    wait_drain("t4_drain", 30);

    // 5: FIFO runs dry with a read in flight
    tick();
    for (int v = 0; v < 3; v++) fifo_push(8'hC0 + 8'(v));
    rd_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.o_fifo_rd) rd_cnt++;
    end
    chk("t5_rd_cnt", rd_cnt, 3);
    chk("t5_rd_off", bus.o_fifo_rd, 0);
    chk("t5_drain",  exp_q.size(), 0);

    // 6: asynchronous reset with two buffered words
    tick();
    bus.i_ready = 1'b0;
    for (int v = 0; v < 4; v++) fifo_push(8'h90 + 8'(v));
    for (int i = 0; i < 10 && bus.o_level != 2; i++) @(negedge clk);
    chk("t6_level_pre", bus.o_level, 2);
    tick();
    rst_n  = 1'b0;
    wr_ptr = 0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", bus.o_valid, 0);
    chk("t6_rst_level", bus.o_level, 0);
    chk("t6_rst_rd",    bus.o_fifo_rd, 0);
    tick();
    tick();
    rst_n = 1'b1;
    fifo_push(8'h5C);
    bus.i_ready = 1'b1;
    wait_drain("t6_drain", 10);
    chk("err_final", bus.o_err, 0);
    chk("underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
